// File: rtl/cm_merge_arb_if.sv
// Send/Ack bundle for the two-into-one merge: upstream channels a/b, one downstream channel, status.
// Carries no logic, so it adds no latency.
// Backpressure is the 4-phase Send/Ack handshake on each channel.
interface cm_merge_arb_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             CM_Send_in_a;
    logic [WIDTH-1:0] CM_Data_in_a;
    logic             CM_Ack_out_a;
    logic             CM_Send_in_b;
    logic [WIDTH-1:0] CM_Data_in_b;
    logic             CM_Ack_out_b;
    logic             CM_Send_out;
    logic [WIDTH-1:0] CM_Data_out;
    logic             CM_Ack_in;
    logic             CM_Grant;
    logic             CM_CP;
    logic [CNT_W-1:0] CM_Count;

    // The merge block drives acks, the downstream request and status.
    modport master (
        input  CM_Send_in_a, CM_Data_in_a, CM_Send_in_b, CM_Data_in_b, CM_Ack_in,
        output CM_Ack_out_a, CM_Ack_out_b, CM_Send_out, CM_Data_out,
               CM_Grant, CM_CP, CM_Count
    );

    // The environment drives upstream requests/payloads and the downstream ack.
    modport slave (
        output CM_Send_in_a, CM_Data_in_a, CM_Send_in_b, CM_Data_in_b, CM_Ack_in,
        input  CM_Ack_out_a, CM_Ack_out_b, CM_Send_out, CM_Data_out,
               CM_Grant, CM_CP, CM_Count
    );
endinterface

// File: rtl/cm_merge_arb.sv
// Round-robin merge of two 4-phase Send/Ack channels onto one registered downstream channel.
// Request sampled at edge k gives Send_out/Ack/CP after edge k; back-to-back packets every 3 cycles.
// One packet in flight; other requests stay pending until the downstream and upstream handshakes both return to zero.
module cm_merge_arb #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic           CLK,
    input  logic           MR,
    cm_merge_arb_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             send_out_q, send_out_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             cp_q, cp_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic req_any;
    logic win_b;
    logic capture;
    logic drain_done;

    assign req_any    = bus.CM_Send_in_a | bus.CM_Send_in_b;
    // On a tie the channel that did not win last time gets the slot.
    assign win_b      = (bus.CM_Send_in_a & bus.CM_Send_in_b) ? ~last_q : bus.CM_Send_in_b;
    assign capture    = (state_q == IDLE) & req_any;
    // Both sides of the 4-phase exchange must be back at zero before the next packet.
    assign drain_done = (state_q == DRAIN) & ~bus.CM_Ack_in & ~ack_a_q & ~ack_b_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (!MR) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: capture, wait for downstream ack, wait for both handshakes to settle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any)        state_d = BUSY;
            BUSY:    if (bus.CM_Ack_in)  state_d = DRAIN;
            DRAIN:   if (drain_done)     state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Output next-values; upstream release is independent of the FSM state.
    always_comb begin
        ack_a_d    = ack_a_q & bus.CM_Send_in_a;
        ack_b_d    = ack_b_q & bus.CM_Send_in_b;
        send_out_d = send_out_q;
        data_d     = data_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cp_d       = 1'b0;
        count_d    = count_q;

        if (capture) begin
            send_out_d = 1'b1;
            cp_d       = 1'b1;
            grant_d    = win_b;
            last_d     = win_b;
            if (win_b) begin
                ack_b_d = 1'b1;
                data_d  = bus.CM_Data_in_b;
            end else begin
                ack_a_d = 1'b1;
                data_d  = bus.CM_Data_in_a;
            end
        end

        if ((state_q == BUSY) && bus.CM_Ack_in) begin
            send_out_d = 1'b0;
        end

        if (drain_done) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Output registers; reset abandons any packet in flight and makes a win the first tie.
    always_ff @(posedge CLK) begin
        if (!MR) begin
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            send_out_q <= 1'b0;
            data_q     <= '0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            cp_q       <= 1'b0;
            count_q    <= '0;
        end else begin
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            send_out_q <= send_out_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cp_q       <= cp_d;
            count_q    <= count_d;
        end
    end

    assign bus.CM_Ack_out_a = ack_a_q;
    assign bus.CM_Ack_out_b = ack_b_q;
    assign bus.CM_Send_out  = send_out_q;
    assign bus.CM_Data_out  = data_q;
    assign bus.CM_Grant     = grant_q;
    assign bus.CM_CP        = cp_q;
    assign bus.CM_Count     = count_q;

endmodule
